wb_slave_switch: RTL and testbench
==================================

WB_SLAVE_SWITCH -- requirements
Module: wb_slave_switch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the number of BUSY cycles without slave ack before the transfer is aborted with an error; legal range 1..1023.
REQ-002 Parameter NUM_SLAVES, default 16, is the slave port count and equals the width of the one-hot select code.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous reset, active-low; takes effect at a rising clk edge while 0.
REQ-005 m_cyc_i, m_stb_i, m_we_i  input  1 each  Wishbone classic master request.
REQ-006 m_adr_i  input  32  physical (translated) address; m_sel_i  input  4  byte lanes; m_dat_i  input  32  write data.
REQ-007 sel_i  input  NUM_SLAVES  one-hot slave select from address translation; all-zero means unmapped.
REQ-008 m_dat_o  output  32  read data; m_ack_o  output  1  transfer complete; m_err_o  output  1  unmapped or timed out.
REQ-009 s_adr_o  output  32, s_dat_o  output  32, s_sel_o  output  4, s_we_o  output  1  shared slave request bus.
REQ-010 s_cyc_o, s_stb_o  output  NUM_SLAVES each  one-hot per-slave strobes.
REQ-011 s_dat_i  input  32*NUM_SLAVES  slave read data, slave k on bits [32k+31:32k]; s_ack_i  input  NUM_SLAVES  per-slave ack.

Function
REQ-012 States: IDLE, BUSY, RESP, RELEASE.
REQ-013 IDLE: when m_cyc_i & m_stb_i are high and sel_i is nonzero, latch m_adr_i, m_dat_i, m_sel_i, m_we_i and sel_i, clear the timeout counter, and go to BUSY.
REQ-014 IDLE with the request high and sel_i zero: go to RESP with an error pending; no slave strobe is ever raised.
REQ-015 sel_i with more than one bit set counts as unmapped (error, no slave access).
REQ-016 BUSY: drive s_cyc_o and s_stb_o equal to the latched select and the s_* bus from the latched fields; master inputs are ignored.
REQ-017 BUSY with the s_ack_i bit of the selected slave high: capture that slave's s_dat_i slice into m_dat_o (reads only; m_dat_o holds otherwise), deassert strobes next cycle, go to RESP with success.
REQ-018 Acks from unselected slaves are ignored.
REQ-019 BUSY: the counter increments each cycle without ack; at count == TIMEOUT_CYCLES-1 go to RESP with error and drop strobes; an ack in that same cycle wins (success).
REQ-020 RESP lasts exactly one cycle: m_ack_o=1 on success or m_err_o=1 on error, never both; then go to RELEASE.
REQ-021 RELEASE: hold until m_stb_i==0, then go to IDLE; prevents a held strobe from starting a second transfer.
REQ-022 Latency for a zero-wait slave (ack in first BUSY cycle): request at cycle 0, strobe at cycle 1, m_ack_o at cycle 2.
REQ-023 m_cyc_i dropping in BUSY does not abort; the slave cycle completes and the response is still issued.

Reset
REQ-024 On rst==0 at a clk edge: state=IDLE; m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o = 0; m_dat_o, s_adr_o, s_dat_o, s_sel_o, counter = 0.
REQ-025 Reset in BUSY drops all strobes on the same edge; no response is issued for the aborted transfer.

Structure
REQ-026 The shared defines file holds the select constants (WB_SELECT_RAM/ROM/FLASH/UART/UART_STAT/DIGSEG/PS2/ZERO), the state encodings and the default timeout.
REQ-027 One sub-module, wb_timeout_counter (enable/clear/expire), is natural; the rest stays flat.

Verification
REQ-028 Read, sel_i=WB_SELECT_RAM, slave acks in the 1st BUSY cycle with 32'hDEADBEEF -> m_ack_o at cycle 2, m_dat_o=32'hDEADBEEF, RAM strobe exactly 1 cycle.
REQ-029 Write to UART (adr 32'h1FD003F8, dat 32'h41) with 3 wait states -> s_dat_o=32'h41, s_we_o=1 for 4 cycles, single m_ack_o pulse.
REQ-030 sel_i=0 -> m_err_o for one cycle at cycle 1, s_stb_o stays 0.
REQ-031 TIMEOUT_CYCLES=8, slave never acks -> m_err_o after 8 BUSY cycles, strobes low from then on.
REQ-032 m_stb_i held high 5 cycles after ack -> no second transfer until m_stb_i drops; rst=0 mid-BUSY -> strobes 0 next edge, no ack/err.
REQ-033 Unselected slave acks during BUSY -> ignored; completion only on the selected ack.

Source files
------------

// File: rtl/wb_slave_switch_pkg.sv
// Shared definitions for the Wishbone slave switch: slave select codes,
// FSM state encodings and the default bus timeout.
package wb_slave_switch_pkg;

    localparam int SEL_WIDTH = 16;

    localparam logic [SEL_WIDTH-1:0] WB_SELECT_ZERO      = 16'h0000;
    localparam logic [SEL_WIDTH-1:0] WB_SELECT_RAM       = 16'h0001;
    localparam logic [SEL_WIDTH-1:0] WB_SELECT_ROM       = 16'h0002;
    localparam logic [SEL_WIDTH-1:0] WB_SELECT_FLASH     = 16'h0004;
    localparam logic [SEL_WIDTH-1:0] WB_SELECT_UART      = 16'h0008;
    localparam logic [SEL_WIDTH-1:0] WB_SELECT_UART_STAT = 16'h0010;
    localparam logic [SEL_WIDTH-1:0] WB_SELECT_DIGSEG    = 16'h0020;
    localparam logic [SEL_WIDTH-1:0] WB_SELECT_PS2       = 16'h0040;

    localparam int DEFAULT_TIMEOUT = 255;

    // Wide enough for the largest legal timeout of 1023 cycles.
    localparam int CNT_WIDTH = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESP    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts stalled bus cycles and flags expiry once LIMIT cycles have been spent
// without an acknowledge.
module wb_timeout_counter
    import wb_slave_switch_pkg::*;
#(
    parameter int LIMIT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == CNT_WIDTH'(LIMIT - 1));

endmodule

// File: rtl/wb_slave_switch.sv
// Routes one Wishbone classic master to a one-hot selected slave, returning
// ack on completion and err for unmapped selects or stalled slaves.
module wb_slave_switch
    import wb_slave_switch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int NUM_SLAVES     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       m_cyc_i,
    input  logic                       m_stb_i,
    input  logic                       m_we_i,
    input  logic [31:0]                m_adr_i,
    input  logic [3:0]                 m_sel_i,
    input  logic [31:0]                m_dat_i,
    input  logic [NUM_SLAVES-1:0]      sel_i,
    output logic [31:0]                m_dat_o,
    output logic                       m_ack_o,
    output logic                       m_err_o,
    output logic [31:0]                s_adr_o,
    output logic [31:0]                s_dat_o,
    output logic [3:0]                 s_sel_o,
    output logic                       s_we_o,
    output logic [NUM_SLAVES-1:0]      s_cyc_o,
    output logic [NUM_SLAVES-1:0]      s_stb_o,
    input  logic [32*NUM_SLAVES-1:0]   s_dat_i,
    input  logic [NUM_SLAVES-1:0]      s_ack_i
);

    state_e                state_q;
    logic [NUM_SLAVES-1:0] selLatch_q;
    logic [NUM_SLAVES-1:0] stb_q;
    logic [31:0]           adr_q;
    logic [31:0]           wdat_q;
    logic [31:0]           rdat_q;
    logic [3:0]            lanes_q;
    logic                  we_q;
    logic                  ack_q;
    logic                  err_q;

    logic                  selValid;
    logic                  slaveAck;
    logic [31:0]           slaveRdata;
    logic                  timeoutExpire;
    logic                  busy;

    // A select is only routable when exactly one bit is set.
    assign selValid = (sel_i != '0) && ((sel_i & (sel_i - NUM_SLAVES'(1))) == '0);
    assign slaveAck = |(s_ack_i & selLatch_q);
    assign busy     = (state_q == ST_BUSY);

    always_comb begin
        slaveRdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (selLatch_q[k]) begin
                slaveRdata = slaveRdata | s_dat_i[32*k +: 32];
            end
        end
    end

    wb_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .en_i     (busy && !slaveAck && !timeoutExpire),
        .clr_i    (state_q == ST_IDLE),
        .expire_o (timeoutExpire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            selLatch_q <= '0;
            stb_q      <= '0;
            adr_q      <= '0;
            wdat_q     <= '0;
            rdat_q     <= '0;
            lanes_q    <= '0;
            we_q       <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m_cyc_i && m_stb_i) begin
                        if (selValid) begin
                            adr_q      <= m_adr_i;
                            wdat_q     <= m_dat_i;
                            lanes_q    <= m_sel_i;
                            we_q       <= m_we_i;
                            selLatch_q <= sel_i;
                            stb_q      <= sel_i;
                            state_q    <= ST_BUSY;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= ST_RESP;
                        end
                    end
                end
                // An ack in the expiry cycle still counts as success.
                ST_BUSY: begin
                    if (slaveAck) begin
                        if (!we_q) begin
                            rdat_q <= slaveRdata;
                        end
                        ack_q   <= 1'b1;
                        stb_q   <= '0;
                        we_q    <= 1'b0;
                        state_q <= ST_RESP;
                    end else if (timeoutExpire) begin
                        err_q   <= 1'b1;
                        stb_q   <= '0;
                        we_q    <= 1'b0;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!m_stb_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_dat_o = rdat_q;
    assign m_ack_o = ack_q;
    assign m_err_o = err_q;
    assign s_adr_o = adr_q;
    assign s_dat_o = wdat_q;
    assign s_sel_o = lanes_q;
    assign s_we_o  = we_q;
    assign s_cyc_o = stb_q;
    assign s_stb_o = stb_q;

endmodule

// File: tb/tb_wb_slave_switch.sv
// Self-checking bench for wb_slave_switch: directed scenarios plus randomized
// transfers compared against a cycle-count model of the switch behaviour.
module tb_wb_slave_switch;
    import wb_slave_switch_pkg::*;

    localparam int NS   = 16;
    localparam int TO   = 8;
    localparam int MAXC = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              m_cyc_i, m_stb_i, m_we_i;
    logic [31:0]       m_adr_i, m_dat_i;
    logic [3:0]        m_sel_i;
    logic [NS-1:0]     sel_i;
    logic [31:0]       m_dat_o;
    logic              m_ack_o, m_err_o;
    logic [31:0]       s_adr_o, s_dat_o;
    logic [3:0]        s_sel_o;
    logic              s_we_o;
    logic [NS-1:0]     s_cyc_o, s_stb_o;
    logic [32*NS-1:0]  s_dat_i;
    logic [NS-1:0]     s_ack_i;

    wb_slave_switch #(
        .TIMEOUT_CYCLES(TO),
        .NUM_SLAVES    (NS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_adr_i (m_adr_i),
        .m_sel_i (m_sel_i),
        .m_dat_i (m_dat_i),
        .sel_i   (sel_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rdatModel;

    logic [NS-1:0] trStb  [MAXC];
    logic [NS-1:0] trCyc  [MAXC];
    logic          trAck  [MAXC];
    logic          trErr  [MAXC];
    logic          trWe   [MAXC];
    logic [31:0]   trMdat [MAXC];
    logic [31:0]   trAdr  [MAXC];
    logic [31:0]   trSdat [MAXC];
    logic [3:0]    trLanes[MAXC];
    int            traceLen;

    // Timing model: unmapped -> err in cycle 1; ack after 'waits' stall cycles
    // -> ack in cycle waits+2; no ack within TO busy cycles -> err in cycle TO+1.
    function automatic void modelResp(input logic [NS-1:0] sel, input int waits,
                                      output int resp, output bit isErr, output int stbLast);
        bit mapped;
        mapped = (sel != '0) && ($countones(sel) == 1);
        if (!mapped) begin
            resp = 1; isErr = 1'b1; stbLast = 0;
        end else if (waits < TO) begin
            resp = waits + 2; isErr = 1'b0; stbLast = waits + 1;
        end else begin
            resp = TO + 1; isErr = 1'b1; stbLast = TO;
        end
    endfunction

    // Drives one request and a simple slave, recording the DUT outputs of
    // every cycle. noiseMode: 0 none, 1 random unselected acks, 2 all unselected ack.
    task automatic applyStimulus(input logic [NS-1:0] sel, input logic we,
                                 input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] lanes, input int waits,
                                 input logic [31:0] rdata, input int noiseMode,
                                 input int stbCycles);
        int nc;
        logic [NS-1:0] noiseBits;
        nc = ((stbCycles > TO + 1) ? stbCycles : TO + 1) + 3;
        for (int k = 0; k < NS; k++) begin
            s_dat_i[32*k +: 32] = sel[k] ? rdata : $urandom;
        end
        @(negedge clk);
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we;
        m_adr_i = adr; m_dat_i = dat; m_sel_i = lanes; sel_i = sel;
        s_ack_i = '0;
        for (int c = 1; c < nc; c++) begin
            @(negedge clk);
            trStb[c] = s_stb_o; trCyc[c] = s_cyc_o; trAck[c] = m_ack_o;
            trErr[c] = m_err_o; trWe[c] = s_we_o; trMdat[c] = m_dat_o;
            trAdr[c] = s_adr_o; trSdat[c] = s_dat_o; trLanes[c] = s_sel_o;
            if (c >= stbCycles) begin
                m_stb_i = 1'b0; m_cyc_i = 1'b0;
            end else begin
                m_cyc_i = 1'($urandom); m_we_i = 1'($urandom);
                m_adr_i = $urandom; m_dat_i = $urandom;
                m_sel_i = 4'($urandom); sel_i = NS'($urandom);
            end
            case (noiseMode)
                1: noiseBits = NS'($urandom) & ~sel;
                2: noiseBits = ~sel;
                default: noiseBits = '0;
            endcase
            s_ack_i = ((c == waits + 1) ? sel : '0) | noiseBits;
        end
        traceLen = nc;
        @(negedge clk);
        m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = '0; sel_i = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; sel_i = '0;
        s_dat_i = '0; s_ack_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({m_ack_o, m_err_o, s_we_o} !== 3'b000) begin errors++;
            $display("[TB] FAIL reset_flags: got %b expected 000", {m_ack_o, m_err_o, s_we_o}); end
        checks++; if ({s_cyc_o, s_stb_o} !== '0) begin errors++;
            $display("[TB] FAIL reset_strobes: got %h expected 0", {s_cyc_o, s_stb_o}); end
        checks++; if ({m_dat_o, s_adr_o, s_dat_o, s_sel_o} !== '0) begin errors++;
            $display("[TB] FAIL reset_data: got %h expected 0", {m_dat_o, s_adr_o, s_dat_o, s_sel_o}); end
        rst = 1'b1;
        rdatModel = '0;
        @(negedge clk);
    endtask

    task automatic test_ram_read();
        int n;
        applyStimulus(WB_SELECT_RAM, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 0, 32'hDEADBEEF, 0, 1);
        checks++; if ({trAck[1], trAck[2], trAck[3]} !== 3'b010) begin errors++;
            $display("[TB] FAIL ram_ack_timing: got %b expected 010", {trAck[1], trAck[2], trAck[3]}); end
        checks++; if (trMdat[2] !== 32'hDEADBEEF) begin errors++;
            $display("[TB] FAIL ram_rdata: got %h expected deadbeef", trMdat[2]); end
        checks++; if (trStb[1] !== WB_SELECT_RAM) begin errors++;
            $display("[TB] FAIL ram_strobe: got %h expected %h", trStb[1], WB_SELECT_RAM); end
        n = 0;
        for (int c = 1; c < traceLen; c++) if (trStb[c] != '0) n++;
        checks++; if (n != 1) begin errors++;
            $display("[TB] FAIL ram_strobe_len: got %0d cycles expected 1", n); end
        rdatModel = 32'hDEADBEEF;
    endtask

    task automatic test_uart_write();
        int nWe, nAck, ackAt;
        applyStimulus(WB_SELECT_UART, 1'b1, 32'h1FD003F8, 32'h41, 4'h1, 3, 32'h5555_AAAA, 0, 1);
        nWe = 0; nAck = 0; ackAt = -1;
        for (int c = 1; c < traceLen; c++) begin
            if (trWe[c] === 1'b1) nWe++;
            if (trAck[c] === 1'b1) begin nAck++; ackAt = c; end
        end
        checks++; if (nWe != 4) begin errors++;
            $display("[TB] FAIL uart_we_len: got %0d expected 4", nWe); end
        checks++; if (nAck != 1 || ackAt != 5) begin errors++;
            $display("[TB] FAIL uart_ack: got %0d pulses at %0d expected 1 at 5", nAck, ackAt); end
        checks++; if (trSdat[4] !== 32'h41 || trAdr[4] !== 32'h1FD003F8) begin errors++;
            $display("[TB] FAIL uart_bus: got %h/%h expected 00000041/1fd003f8", trSdat[4], trAdr[4]); end
        checks++; if (trMdat[6] !== rdatModel) begin errors++;
            $display("[TB] FAIL uart_mdat_hold: got %h expected %h", trMdat[6], rdatModel); end
    endtask

    task automatic test_unmapped(input logic [NS-1:0] sel, input string name);
        int nErr, nStb;
        applyStimulus(sel, 1'b0, 32'hBAD0_0000, 32'h0, 4'hF, 0, 32'h1234_5678, 1, 1);
        nErr = 0; nStb = 0;
        for (int c = 1; c < traceLen; c++) begin
            if (trErr[c] === 1'b1) nErr++;
            if (trStb[c] != '0 || trCyc[c] != '0 || trAck[c] !== 1'b0) nStb++;
        end
        checks++; if (trErr[1] !== 1'b1 || nErr != 1) begin errors++;
            $display("[TB] FAIL %s_err: got err1=%b count=%0d expected 1/1", name, trErr[1], nErr); end
        checks++; if (nStb != 0) begin errors++;
            $display("[TB] FAIL %s_no_access: got %0d active cycles expected 0", name, nStb); end
    endtask

    task automatic test_unselected_ack();
        int ackAt, nStb;
        applyStimulus(WB_SELECT_DIGSEG, 1'b0, 32'h0000_2000, 32'h0, 4'hF, 4, 32'hCAFE_F00D, 2, 1);
        ackAt = -1; nStb = 0;
        for (int c = 1; c < traceLen; c++) begin
            if (trAck[c] === 1'b1) ackAt = c;
            if (trStb[c] != '0) nStb++;
        end
        checks++; if (ackAt != 6 || nStb != 5) begin errors++;
            $display("[TB] FAIL unsel_ack_timing: got ack %0d strobe %0d expected 6/5", ackAt, nStb); end
        checks++; if (trMdat[6] !== 32'hCAFE_F00D) begin errors++;
            $display("[TB] FAIL unsel_ack_rdata: got %h expected cafef00d", trMdat[6]); end
        rdatModel = 32'hCAFE_F00D;
    endtask

    task automatic test_timeout();
        int nStb, errAt;
        applyStimulus(WB_SELECT_ROM, 1'b0, 32'h0000_3000, 32'h0, 4'hF, 99, 32'h0BAD_BEEF, 0, 1);
        nStb = 0; errAt = -1;
        for (int c = 1; c < traceLen; c++) begin
            if (trStb[c] == WB_SELECT_ROM) nStb++;
            if (trErr[c] === 1'b1) errAt = c;
        end
        checks++; if (errAt != TO + 1) begin errors++;
            $display("[TB] FAIL timeout_err: got cycle %0d expected %0d", errAt, TO + 1); end
        checks++; if (nStb != TO || trStb[TO + 1] != '0) begin errors++;
            $display("[TB] FAIL timeout_strobe: got %0d cycles expected %0d", nStb, TO); end
        checks++; if (trMdat[TO + 1] !== rdatModel) begin errors++;
            $display("[TB] FAIL timeout_mdat: got %h expected %h", trMdat[TO + 1], rdatModel); end
    endtask

    task automatic test_back_to_back();
        int nAck, nStb;
        // Strobe held through cycle 7, five cycles beyond the ack in cycle 2.
        applyStimulus(WB_SELECT_RAM, 1'b0, 32'h0000_4000, 32'h0, 4'hF, 0, 32'h1111_2222, 0, 8);
        nAck = 0; nStb = 0;
        for (int c = 1; c < traceLen; c++) begin
            if (trAck[c] === 1'b1 || trErr[c] === 1'b1) nAck++;
            if (trStb[c] != '0) nStb++;
        end
        checks++; if (nAck != 1 || nStb != 1) begin errors++;
            $display("[TB] FAIL held_stb_single: got %0d resp %0d strobe expected 1/1", nAck, nStb); end
        applyStimulus(WB_SELECT_PS2, 1'b0, 32'h0000_5000, 32'h0, 4'hF, 0, 32'h3333_4444, 0, 1);
        checks++; if (trAck[2] !== 1'b1 || trMdat[2] !== 32'h3333_4444) begin errors++;
            $display("[TB] FAIL back_to_back: got ack=%b dat=%h expected 1/33334444", trAck[2], trMdat[2]); end
        rdatModel = 32'h3333_4444;
    endtask

    task automatic test_reset_mid_busy();
        int bad;
        @(negedge clk);
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_adr_i = 32'h6000;
        m_sel_i = 4'hF; sel_i = WB_SELECT_FLASH; s_ack_i = '0;
        repeat (3) @(negedge clk);
        checks++; if (s_stb_o !== WB_SELECT_FLASH) begin errors++;
            $display("[TB] FAIL rst_busy_pre: got %h expected %h", s_stb_o, WB_SELECT_FLASH); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({s_stb_o, s_cyc_o} !== '0 || m_ack_o !== 1'b0 || m_err_o !== 1'b0) begin errors++;
            $display("[TB] FAIL rst_busy_drop: got stb=%h ack=%b err=%b expected 0", s_stb_o, m_ack_o, m_err_o); end
        rst = 1'b1; m_cyc_i = 1'b0; m_stb_i = 1'b0; sel_i = '0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (m_ack_o !== 1'b0 || m_err_o !== 1'b0 || s_stb_o != '0) bad++;
        end
        checks++; if (bad != 0 || m_dat_o !== '0) begin errors++;
            $display("[TB] FAIL rst_busy_after: got %0d bad cycles mdat=%h expected 0/0", bad, m_dat_o); end
        rdatModel = '0;
    endtask

    task automatic test_random();
        logic [NS-1:0] sel;
        logic          we;
        logic [31:0]   adr, dat, rdata, newDat;
        logic [3:0]    lanes;
        int            waits, stbCycles, resp, stbLast, r, b1, b2;
        bit            isErr;
        logic [NS-1:0] expStb;
        for (int t = 0; t < 30; t++) begin
            r = $urandom_range(0, 9);
            b1 = $urandom_range(0, NS - 1);
            if (r == 6) sel = '0;
            else if (r == 7) begin
                b2 = (b1 + $urandom_range(1, NS - 1)) % NS;
                sel = (NS'(1) << b1) | (NS'(1) << b2);
            end else sel = NS'(1) << b1;
            we = 1'($urandom); adr = $urandom; dat = $urandom; rdata = $urandom;
            lanes = 4'($urandom); waits = $urandom_range(0, 10);
            stbCycles = $urandom_range(1, 12);
            applyStimulus(sel, we, adr, dat, lanes, waits, rdata, 1, stbCycles);
            modelResp(sel, waits, resp, isErr, stbLast);
            newDat = (!isErr && !we) ? rdata : rdatModel;
            for (int c = 1; c < traceLen; c++) begin
                expStb = (c <= stbLast) ? sel : '0;
                checks++; if (trStb[c] !== expStb || trCyc[c] !== expStb) begin errors++;
                    $display("[TB] FAIL rnd%0d_stb c%0d: got %h/%h expected %h", t, c, trStb[c], trCyc[c], expStb); end
                checks++; if (trAck[c] !== (c == resp && !isErr) || trErr[c] !== (c == resp && isErr)) begin errors++;
                    $display("[TB] FAIL rnd%0d_resp c%0d: got ack=%b err=%b expected resp at %0d err=%b",
                             t, c, trAck[c], trErr[c], resp, isErr); end
                checks++; if (trMdat[c] !== ((c >= resp) ? newDat : rdatModel)) begin errors++;
                    $display("[TB] FAIL rnd%0d_mdat c%0d: got %h expected %h", t, c, trMdat[c],
                             (c >= resp) ? newDat : rdatModel); end
                if (c <= stbLast) begin
                    checks++; if (trAdr[c] !== adr || trSdat[c] !== dat || trLanes[c] !== lanes || trWe[c] !== we) begin
                        errors++;
                        $display("[TB] FAIL rnd%0d_bus c%0d: got %h %h %h %b expected %h %h %h %b",
                                 t, c, trAdr[c], trSdat[c], trLanes[c], trWe[c], adr, dat, lanes, we); end
                end
            end
            rdatModel = newDat;
        end
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_uart_write();
        test_unmapped(WB_SELECT_ZERO, "unmapped");
        test_unmapped(WB_SELECT_RAM | WB_SELECT_UART, "multi_sel");
        test_unselected_ack();
        test_timeout();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
